seg_display_sched: RTL and testbench
====================================

SEG_DISPLAY_SCHED -- requirements
Module: seg_display_sched

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, a power of two from 2 to 8.
REQ-002 SHALL have parameter DWELL, default 4096: cycles each digit is shown, at least 1.
REQ-003 SHALL have parameter BLANK, default 256: inter-digit blanking cycles, at least 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 2 bits: req[i] high means requester i wants the display.
REQ-007 SHALL have port data0, input, 32 bits: display word from requester 0.
REQ-008 SHALL have port data1, input, 32 bits: display word from requester 1.
REQ-009 SHALL have port gnt, output, 2 bits: one-hot current owner, or 00 when no owner.
REQ-010 SHALL have port digit, output, $clog2(DIGITS) bits: index of the active digit.
REQ-011 SHALL have port data, output, 32 bits: word latched for the current frame.
REQ-012 SHALL have port blank, output, 1 bit: high forces all anodes off.
REQ-013 SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new frame begins.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHOW and BLANK; all outputs SHALL be registered.
REQ-015 In IDLE with req!=00 at cycle N, the block SHALL arbitrate and, at N+1, drive gnt, latch data, pulse frame_start, set digit=0 and blank=0, and enter SHOW.
REQ-016 SHOW SHALL last exactly DWELL cycles with blank=0, then enter BLANK.
REQ-017 BLANK SHALL last exactly BLANK cycles with blank=1; digit SHALL then increment and the FSM SHALL return to SHOW.
REQ-018 Frame boundary: when BLANK ends on digit DIGITS-1, the block SHALL re-arbitrate instead of incrementing.
REQ-019 At a frame boundary with req!=00, the block SHALL grant, latch, pulse frame_start, set digit=0 and enter SHOW with no gap cycle; frame length SHALL be DIGITS*(DWELL+BLANK) cycles.
REQ-020 At a frame boundary with req==00, the block SHALL enter IDLE with gnt=00 and blank=1; data SHALL retain its last value.
REQ-021 Arbitration SHALL be round-robin: a single request wins; with req==11, the requester not granted last wins; the pointer SHALL reset to favour requester 0.
REQ-022 Grants SHALL change only at frame boundaries; dropping req mid-frame SHALL NOT end the frame early.
REQ-023 Changes on data0/data1 mid-frame SHALL NOT affect data until the next frame_start.
REQ-024 digit SHALL never reach or exceed DIGITS.

Reset
REQ-025 While rst_n=0, the block SHALL hold state IDLE, digit=0, data=0, gnt=00, blank=1, frame_start=0, timer=0 and the round-robin pointer at 0, applied asynchronously, including mid-frame.
REQ-026 The first arbitration SHALL occur on the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro SEG_DISPLAY_SCHED_BLANK_EN defined: the BLANK state SHALL exist as in REQ-017.
REQ-028 Macro SEG_DISPLAY_SCHED_BLANK_EN undefined: the BLANK state and parameter usage SHALL be removed, digits SHALL advance directly after SHOW, the frame SHALL be DIGITS*DWELL cycles, and blank SHALL be high only in IDLE and reset.

Structure
REQ-029 Package seg_sched_pkg SHALL hold the FSM state enum and the DIGITS, DWELL and BLANK default constants.
REQ-030 Sub-module dwell_timer SHALL be a loadable down-counter with a one-cycle expire pulse, shared by SHOW and BLANK.

Verification (DIGITS=8, DWELL=3, BLANK=2, macro defined unless stated)
REQ-031 Reset, then req=00 for 100 cycles -> blank=1, gnt=00, digit=0, frame_start never pulses.
REQ-032 req=01 and data0=0x12345678 at cycle 10 -> at cycle 11 gnt=01, frame_start=1 and data=0x12345678; each digit shows 3 cycles then blanks 2 cycles; the next frame_start occurs at cycle 51.
REQ-033 req=11 held -> gnt sequence is 01, 10, 01, 10 with frame_start every 40 cycles.
REQ-034 data0 changed to 0xDEADBEEF at digit 4, then req dropped at digit 6 -> data stays 0x12345678 and gnt stays 01 to the frame end; then IDLE with gnt=00 and blank=1.
REQ-035 rst_n pulsed low at digit 5 -> all outputs take reset values before the next clk edge.
REQ-036 Macro undefined, req=01 -> blank=0 throughout the frame, frame length 24 cycles, digit steps every 3 cycles.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared types and defaults for the seven-segment display scheduler.
// Optional feature macro: SEG_DISPLAY_SCHED_BLANK_EN (adds the inter-digit BLANK state).
package seg_sched_pkg;

  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned DWELL_DEF  = 4096;
  localparam int unsigned BLANK_DEF  = 256;

  // Scheduler FSM states; encoding is fixed so the debug port is stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1
`ifdef SEG_DISPLAY_SCHED_BLANK_EN
    ,
    ST_BLANK = 2'd2
`endif
  } state_t;

  // Larger of two unsigned values, used to size the shared dwell timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Round-robin pick between two requesters. prio selects who wins a tie
  // (0 favours requester 0). Returns a one-hot grant, or 00 with no request.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = prio ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_sched_dwell_timer.sv
// Loadable down-counter shared by the SHOW and BLANK phases of the scheduler.
// expire_o is high for the single cycle in which the count sits at 1, so a
// load of N yields expire N-1 cycles later and the owner changes phase on
// the following edge, giving a phase of exactly N cycles.
// Optional feature macro: SEG_DISPLAY_SCHED_BLANK_EN (no effect on this file).
module dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/seg_display_sched.sv
// Time-multiplexed display scheduler: two requesters share one display,
// ownership is decided round-robin once per frame, and each frame walks
// every digit with a fixed dwell (and optional blanking gap).
// Optional feature macro: SEG_DISPLAY_SCHED_BLANK_EN. When defined, every
// digit is followed by BLANK cycles with blank high; when undefined, digits
// advance straight after their dwell and blank is only high while idle.
//
// Request protocol: req[i] is a level, not a handshake. It is sampled only
// when a frame may start (idle, or the last cycle of a frame); gnt is
// one-hot for the whole frame that follows and is never revoked mid-frame.
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned DWELL  = DWELL_DEF,
  parameter int unsigned BLANK  = BLANK_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req,
  input  logic [31:0]               data0,
  input  logic [31:0]               data1,
  output logic [1:0]                gnt,
  output logic [$clog2(DIGITS)-1:0] digit,
  output logic [31:0]               data,
  output logic                      blank,
  output logic                      frame_start,
  output state_t                    state_dbg
);

  localparam int unsigned DW = $clog2(DIGITS);
  // Timer is wide enough for either reload value so its shape is the same
  // in both builds.
  localparam int unsigned TW = $clog2(max_u(DWELL, BLANK) + 1);

  localparam logic [TW-1:0] DWELL_LD   = TW'(DWELL);
`ifdef SEG_DISPLAY_SCHED_BLANK_EN
  localparam logic [TW-1:0] BLANK_LD   = TW'(BLANK);
`endif
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [DW-1:0]   digit_q, digit_d;
  logic [31:0]     data_q, data_d;
  logic            blank_q, blank_d;
  logic            fs_q, fs_d;
  logic            prio_q, prio_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expire;
  logic [1:0]      pick;
  logic            start_frame;
  logic            end_frame;

  dwell_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_expire)
  );

  // Next-state and registered-output logic: phase sequencing, then frame
  // boundary handling (re-arbitrate or fall back to idle).
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    digit_d     = digit_q;
    data_d      = data_q;
    blank_d     = blank_q;
    fs_d        = 1'b0;
    prio_d      = prio_q;
    tmr_load    = 1'b0;
    tmr_val     = DWELL_LD;
    pick        = rr_pick(req, prio_q);
    start_frame = 1'b0;
    end_frame   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          start_frame = 1'b1;
        end
      end

      ST_SHOW: begin
        if (tmr_expire) begin
`ifdef SEG_DISPLAY_SCHED_BLANK_EN
          state_d  = ST_BLANK;
          blank_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LD;
`else
          if (digit_q == LAST_DIGIT) begin
            end_frame = 1'b1;
          end else begin
            digit_d  = digit_q + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = DWELL_LD;
          end
`endif
        end
      end

`ifdef SEG_DISPLAY_SCHED_BLANK_EN
      ST_BLANK: begin
        if (tmr_expire) begin
          if (digit_q == LAST_DIGIT) begin
            end_frame = 1'b1;
          end else begin
            state_d  = ST_SHOW;
            digit_d  = digit_q + 1'b1;
            blank_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = DWELL_LD;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Last digit finished: either hand the display to the next owner with
    // no gap, or go idle keeping the last word on data.
    if (end_frame) begin
      if (req != 2'b00) begin
        start_frame = 1'b1;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        blank_d = 1'b1;
        digit_d = '0;
      end
    end

    // New frame: grant, latch the winner's word, restart at digit 0, and
    // move the tie-break towards the requester that just lost.
    if (start_frame) begin
      state_d  = ST_SHOW;
      gnt_d    = pick;
      data_d   = pick[1] ? data1 : data0;
      fs_d     = 1'b1;
      digit_d  = '0;
      blank_d  = 1'b0;
      prio_d   = pick[0];
      tmr_load = 1'b1;
      tmr_val  = DWELL_LD;
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      digit_q <= '0;
      data_q  <= '0;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      digit_q <= digit_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      prio_q  <= prio_d;
    end
  end

  assign gnt         = gnt_q;
  assign digit       = digit_q;
  assign data        = data_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched with DIGITS=8, DWELL=3, BLANK=2.
// Follows SEG_DISPLAY_SCHED_BLANK_EN the same way the design does.
module tb_seg_display_sched;
  import seg_sched_pkg::*;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned DWELL  = 3;
  localparam int unsigned BLANK  = 2;
`ifdef SEG_DISPLAY_SCHED_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int P = BLANK_EN ? (DWELL + BLANK) : DWELL;
  localparam int F = DIGITS * P;
  localparam int W = 66;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [1:0]  gnt;
  logic [2:0]  digit;
  logic [31:0] data;
  logic        blank;
  logic        frame_start;
  state_t      state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seg_display_sched #(
    .DIGITS(DIGITS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .gnt        (gnt),
    .digit      (digit),
    .data       (data),
    .blank      (blank),
    .frame_start(frame_start),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry: {expected frame_start cycle, gnt, data}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int at, input logic [1:0] g, input logic [31:0] d);
    exp_q.push_back({32'(at), g, d});
  endtask

  // Monitor: matches each frame_start against the queue, then checks every
  // cycle of the frame against a digit/blank timing model.
  logic [W-1:0] mon_e;
  logic [1:0]   cur_gnt;
  logic [31:0]  cur_data;
  logic [2:0]   exp_digit;
  logic         exp_blank;
  int           base;
  int           off;
  bit           active = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (frame_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_start actual=1 required=0 (cycle %0d)", cyc);
          active = 1'b0;
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_start_cycle", 64'(cyc), 64'(mon_e[65:34]));
          chk("frame_gnt", 64'(gnt), 64'(mon_e[33:32]));
          chk("frame_data", 64'(data), 64'(mon_e[31:0]));
          cur_gnt  = mon_e[33:32];
          cur_data = mon_e[31:0];
          base     = cyc;
          active   = 1'b1;
        end
      end else if (exp_q.size() != 0 && cyc > int'(exp_q[0][65:34])) begin
        checks++;
        errors++;
        $display("FAIL missing_frame_start actual=none required=cycle_%0d", exp_q[0][65:34]);
        void'(exp_q.pop_front());
      end
      if (active) begin
        off = cyc - base;
        if (off >= F) begin
          active = 1'b0;
        end else begin
          exp_digit = 3'(off / P);
          exp_blank = BLANK_EN && ((off % P) >= DWELL);
          chk("frame_cycle_outputs", 64'({gnt, data, digit, blank}),
              64'({cur_gnt, cur_data, exp_digit, exp_blank}));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle(input string name, input logic [31:0] exp_data);
    chk({name, "_gnt"}, 64'(gnt), 64'(2'b00));
    chk({name, "_blank"}, 64'(blank), 64'(1'b1));
    chk({name, "_digit"}, 64'(digit), 64'(3'd0));
    chk({name, "_data"}, 64'(data), 64'(exp_data));
    chk({name, "_frame_start"}, 64'(frame_start), 64'(1'b0));
    chk({name, "_state"}, 64'(state_dbg), 64'(2'd0));
  endtask

  int s1;
  int s2;
  int k;

  initial begin
    // Reset held over several edges.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset", 32'h0);

    // Release, then no requests for 100 cycles.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk_idle("idle_100", 32'h0);

    // Single requester 0: two back-to-back frames, data0 changes at digit 4
    // of frame 2, request dropped at digit 6 of frame 2.
    req   = 2'b01;
    data0 = 32'h12345678;
    s1    = cyc + 1;
    push_frame(s1, 2'b01, 32'h12345678);
    push_frame(s1 + F, 2'b01, 32'h12345678);
    wait_cyc(s1 + F + 4 * P);
    data0 = 32'hDEADBEEF;
    wait_cyc(s1 + F + 6 * P);
    req = 2'b00;
    wait_cyc(s1 + 2 * F);
    chk_idle("after_drop", 32'h12345678);
    repeat (10) @(posedge clk);
    #1;
    chk_idle("idle_hold", 32'h12345678);

    // Mid-frame reset at digit 5: outputs clear before the next edge.
    req   = 2'b01;
    data0 = 32'h55AA55AA;
    s2    = cyc + 1;
    push_frame(s2, 2'b01, 32'h55AA55AA);
    wait_cyc(s2 + 5 * P + 1);
    chk("pre_reset_digit", 64'(digit), 64'(3'd5));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_idle("async_reset", 32'h0);
    req   = 2'b11;
    data0 = 32'hA0A0A0A0;
    data1 = 32'hB1B1B1B1;
    @(posedge clk);
    #1;
    chk_idle("reset_held", 32'h0);

    // Both requesting from a fresh reset: 01, 10, 01, 10, one frame each.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    k = cyc;
    push_frame(k + 1,         2'b01, 32'hA0A0A0A0);
    push_frame(k + 1 + F,     2'b10, 32'hB1B1B1B1);
    push_frame(k + 1 + 2 * F, 2'b01, 32'hA0A0A0A0);
    push_frame(k + 1 + 3 * F, 2'b10, 32'hB1B1B1B1);
    wait_cyc(k + 1 + 3 * F + 2);
    req = 2'b00;
    wait_cyc(k + 1 + 4 * F);
    chk_idle("rr_end", 32'hB1B1B1B1);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
